subtractor: RTL and testbench

Parameterised two's-complement integer subtractor for the FPU basic-arithmetic library; computes `res = a - b` modulo 2^SIZE with status flags. Used by exponent-difference and mantissa-alignment paths. Result and flags are registered, giving a one-cycle latency, and a valid bit travels with them.

---
 rtl/subtractor.sv | 80 ++++++++
 tb/tb_subtractor.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/subtractor.sv
// Registered two's-complement subtractor: res = a - b mod 2^SIZE, with borrow,
// signed-overflow, zero and negative flags. One-cycle latency, valid travels along.
module subtractor #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic [SIZE-1:0] res,
  output logic            out_valid,
  output logic            borrow,
  output logic            ovf,
  output logic            zero,
  output logic            neg
);

  localparam int NGRP = (SIZE + 3) / 4;

  logic [SIZE-1:0] g;
  logic [SIZE-1:0] p;
  logic [SIZE:0]   c;
  logic [SIZE-1:0] diff;
  logic            grp_g;
  logic            grp_p;
  logic            cout;
  logic            ovf_d;

  // a - b is a + ~b + 1, so generate/propagate use the inverted subtrahend.
  assign g = a & ~b;
  assign p = a ^ ~b;

  // Each carry inside a 4-bit group is formed from the group's carry-in and the
  // running group generate/propagate, so groups look ahead internally and ripple
  // between one another. The last group may be narrower than 4 bits.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    c     = '0;
    c[0]  = 1'b1;
    grp_g = 1'b0;
    grp_p = 1'b1;
    for (int gi = 0; gi < NGRP; gi++) begin
      grp_g = 1'b0;
      grp_p = 1'b1;
      for (int k = 0; k < 4 && (4 * gi + k) < SIZE; k++) begin
        grp_g = g[4*gi+k] | (p[4*gi+k] & grp_g);
        grp_p = grp_p & p[4*gi+k];
        c[4*gi+k+1] = grp_g | (grp_p & c[4*gi]);
      end
    end
  end

  assign diff  = p ^ c[SIZE-1:0];
  assign cout  = c[SIZE];
  assign ovf_d = (a[SIZE-1] != b[SIZE-1]) && (diff[SIZE-1] != a[SIZE-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res       <= '0;
      out_valid <= 1'b0;
      borrow    <= 1'b0;
      ovf       <= 1'b0;
      // NOTE: zero resets high so the flag agrees with the cleared result.
      zero      <= 1'b1;
      neg       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      out_valid <= in_valid;
      if (in_valid) begin
        res    <= diff;
        borrow <= ~cout;
        ovf    <= ovf_d;
        zero   <= (diff == '0);
        neg    <= diff[SIZE-1];
      end
    end
  end

endmodule

// File: tb/tb_subtractor.sv
// Self-checking bench for subtractor: table vectors at widths 32/7/1, a random
// stream through a scoreboard queue, hold behaviour and asynchronous reset.
module tb_subtractor;

  typedef struct packed {
    logic        valid;
    logic        borrow;
    logic        ovf;
    logic        zero;
    logic        neg;
    logic [63:0] res;
  } exp_t;

  typedef struct {
    int          w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic        borrow;
    logic        ovf;
    logic        zero;
    logic        neg;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  logic        iv1, iv7, iv32;
  logic [0:0]  a1, b1, r1;
  logic [6:0]  a7, b7, r7;
  logic [31:0] a32, b32, r32;
  logic ov1, bo1, of1, z1, n1;
  logic ov7, bo7, of7, z7, n7;
  logic ov32, bo32, of32, z32, n32;

  int n_checks = 0;
  int n_pass   = 0;
  exp_t sb[$];
  exp_t last32;

  always #5 clk = ~clk;

  subtractor #(.SIZE(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .a(a32), .b(b32),
    .res(r32), .out_valid(ov32), .borrow(bo32), .ovf(of32), .zero(z32), .neg(n32)
  );
  subtractor #(.SIZE(7)) dut7 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv7), .a(a7), .b(b7),
    .res(r7), .out_valid(ov7), .borrow(bo7), .ovf(of7), .zero(z7), .neg(n7)
  );
  subtractor #(.SIZE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .a(a1), .b(b1),
    .res(r1), .out_valid(ov1), .borrow(bo1), .ovf(of1), .zero(z1), .neg(n1)
  );

  // Reference model built on plain integer arithmetic at the requested width.
  function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b);
    exp_t        e;
    logic [63:0] mask;
    logic [63:0] am, bm;
    longint      sa, sb_v, d, lim;
    mask = (64'd1 << w) - 64'd1;
    am   = a & mask;
    bm   = b & mask;
    sa   = longint'(am);
    sb_v = longint'(bm);
    if (am[w-1]) sa   = sa - longint'(64'd1 << w);
    if (bm[w-1]) sb_v = sb_v - longint'(64'd1 << w);
    d    = sa - sb_v;
    lim  = longint'(64'd1 << (w - 1)) - 1;
    e.valid  = 1'b1;
    e.res    = (am - bm) & mask;
    e.borrow = (am < bm);
    e.ovf    = (d > lim) || (d < -lim - 1);
    e.zero   = (e.res == 64'd0);
    e.neg    = e.res[w-1];
    return e;
  endfunction

  function automatic exp_t sample(input int w);
    exp_t s;
    case (w)
      1:       s = '{ov1,  bo1,  of1,  z1,  n1,  {63'd0, r1}};
      7:       s = '{ov7,  bo7,  of7,  z7,  n7,  {57'd0, r7}};
      default: s = '{ov32, bo32, of32, z32, n32, {32'd0, r32}};
    endcase
    return s;
  endfunction

  task automatic check(input string name, input exp_t got, input exp_t want);
    n_checks++;
    if (got !== want) begin
      $display("FAIL %s: got v=%b borrow=%b ovf=%b zero=%b neg=%b res=%h, want v=%b borrow=%b ovf=%b zero=%b neg=%b res=%h",
               name, got.valid, got.borrow, got.ovf, got.zero, got.neg, got.res,
               want.valid, want.borrow, want.ovf, want.zero, want.neg, want.res);
    end else begin
      n_pass++;
    end
  endtask

  // Called just after a rising edge: drive one cycle of stimulus, queue the
  // expectation, then compare once the next edge has captured it.
  task automatic step(input string name, input int w, input logic v,
                      input logic [63:0] a, input logic [63:0] b, input exp_t e);
    exp_t want;
    iv1 = 1'b0; iv7 = 1'b0; iv32 = 1'b0;
    case (w)
      1:       begin iv1  = v; a1  = a[0:0];  b1  = b[0:0];  end
      7:       begin iv7  = v; a7  = a[6:0];  b7  = b[6:0];  end
      default: begin iv32 = v; a32 = a[31:0]; b32 = b[31:0]; end
    endcase
    sb.push_back(e);
    @(posedge clk);
    #1;
    want = sb.pop_front();
    check(name, sample(w), want);
    if (w == 32 && v) last32 = e;
  endtask

  task automatic check_reset(input string name);
    exp_t rst_e;
    rst_e = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0};
    check({name, "_w32"}, sample(32), rst_e);
    check({name, "_w7"},  sample(7),  rst_e);
    check({name, "_w1"},  sample(1),  rst_e);
  endtask

  vec_t vecs[11];

  initial begin
    exp_t e;
    logic [63:0] ra, rb;

    vecs[0]  = '{32, 64'h64,       64'h19,       64'h4B,       1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{32, 64'h0,        64'h1,        64'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{32, 64'hDEADBEEF, 64'hDEADBEEF, 64'h0,        1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{32, 64'h80000000, 64'h1,        64'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{32, 64'h7FFFFFFF, 64'hFFFFFFFF, 64'h80000000, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1,  64'h0,        64'h0,        64'h0,        1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1,  64'h0,        64'h1,        64'h1,        1'b1, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1,  64'h1,        64'h0,        64'h1,        1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1,  64'h1,        64'h1,        64'h0,        1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{7,  64'h00,       64'h7F,       64'h01,       1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{7,  64'h3F,       64'h40,       64'h7F,       1'b1, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b1;
    iv1 = 1'b0; iv7 = 1'b0; iv32 = 1'b0;
    a1 = '0; b1 = '0; a7 = '0; b7 = '0; a32 = '0; b32 = '0;
    last32 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0};

    // Asynchronous reset asserted before any clock edge.
    #2 rst_n = 1'b0;
    #1 check_reset("reset_async");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vecs[i]) begin
      e = '{1'b1, vecs[i].borrow, vecs[i].ovf, vecs[i].zero, vecs[i].neg, vecs[i].res};
      step($sformatf("vec%0d_w%0d", i, vecs[i].w), vecs[i].w, 1'b1, vecs[i].a, vecs[i].b, e);
    end

    for (int i = 0; i < 100; i++) begin
      ra = {32'd0, $urandom};
      rb = (i % 10 == 3) ? ra : {32'd0, $urandom};
      step($sformatf("stream%0d", i), 32, 1'b1, ra, rb, model(32, ra, rb));
    end

    for (int i = 0; i < 2; i++) begin
      e = last32;
      e.valid = 1'b0;
      step($sformatf("hold%0d", i), 32, 1'b0, {32'd0, $urandom}, {32'd0, $urandom}, e);
    end

    // Reset mid-cycle after a capture clears the result immediately.
    iv32 = 1'b1; a32 = 32'd5; b32 = 32'd3;
    @(posedge clk);
    #1 check("pre_reset_capture", sample(32), model(32, 64'd5, 64'd3));
    iv32 = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset("reset_mid");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 check("post_reset_idle", sample(32), '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0});

    step("recover", 32, 1'b1, 64'h10, 64'h20, model(32, 64'h10, 64'h20));
    step("recover_w7", 7, 1'b1, 64'h55, 64'h2A, model(7, 64'h55, 64'h2A));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
